bcd2bin_serial: RTL and testbench
=================================

BCD2BIN_SERIAL -- requirements
Module: bcd2bin_serial

Interface
REQ-001 Parameter NDIG, default 5: number of BCD input digits, legal range 1..8.
REQ-002 Parameter BIN_W, default 17: binary result width, legal range 4..32; it also sets the number of shift steps.
REQ-003 clk  input  1: single clock; all flops update on its rising edge.
REQ-004 rst  input  1: synchronous, active-low reset.
REQ-005 start  input  1: request a conversion; sampled only in IDLE.
REQ-006 bcd_in  input  4*NDIG: packed BCD operand, digit 0 in bits [3:0]; sampled on the cycle start is accepted.
REQ-007 busy  output  1: high while a conversion is in progress (states LOAD and SHIFT).
REQ-008 done  output  1: one-cycle pulse when the result is valid.
REQ-009 bin_out  output  BIN_W: binary result; held until the next accepted start.
REQ-010 err  output  1: the accepted operand held a digit greater than 9; held with bin_out.
REQ-011 ovf  output  1: the operand value is 2^BIN_W or more; held with bin_out.

Function
REQ-012 The FSM has states IDLE, LOAD, SHIFT and DONE.
  - IDLE->LOAD when start=1.
  - LOAD->SHIFT, or LOAD->DONE when err is detected.
  - SHIFT->DONE after exactly BIN_W shift steps.
  - DONE->IDLE unconditionally.
REQ-013 In LOAD, the working register {bcd_part[4*NDIG-1:0], bin_part[BIN_W-1:0]} is loaded with {bcd_in, 0} and the step counter is cleared.
REQ-014 In LOAD, err is set when any 4-bit digit of bcd_in exceeds 9.
REQ-015 Each SHIFT cycle does the following in one cycle:
  - logically shift the whole working register right by 1, inserting 0 at the MSB;
  - then, in each bcd_part digit of the shifted value that is 8 or more, subtract 3;
  - register the result and increment the counter.
REQ-016 Entering DONE with err=0:
  - bin_out takes bin_part;
  - ovf takes (bcd_part != 0).
REQ-017 Entering DONE with err=1: bin_out=0 and ovf=0.
REQ-018 done=1 only in DONE; latency is BIN_W+2 cycles from start sampled high to the done pulse (or 2 cycles when err=1).
REQ-019 start is ignored while busy or in DONE; no queuing.
REQ-020 bcd_in changes after acceptance do not affect the result.
REQ-021 Back-to-back: start high in the cycle after done is accepted normally.
REQ-022 Boundary operands:
  - operand 0 gives bin_out=0 with err=0 and ovf=0;
  - the all-9s operand converts exactly when 10^NDIG-1 < 2^BIN_W, otherwise ovf=1 and bin_out equals the value mod 2^BIN_W.
REQ-023 err and ovf are cleared on entry to LOAD; bin_out keeps its old value until DONE.

Reset
REQ-024 With rst=0 at a rising edge, the block does the following regardless of state, including mid-conversion:
  - FSM goes to IDLE;
  - working register and counter clear to 0;
  - bin_out=0, busy=0, done=0, err=0, ovf=0.
REQ-025 A start asserted in the same cycle as reset is dropped.
REQ-026 The first start that can be accepted is on the first edge with rst=1.

Structure
REQ-027 A shared package bcd2bin_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3);
  - the function computing the counter width, clog2(BIN_W+1).
REQ-028 The sub-module bcd_digit_corr is purely combinational: 4-bit in, 4-bit out, subtract 3 when the input is 8 or more.
REQ-029 bcd_digit_corr is instantiated NDIG times with a generate loop.
REQ-030 The FSM, counter and working register live in bcd2bin_serial.

Verification
REQ-031 Conversion: defaults, bcd_in=20'h00255, start for 1 cycle -> done 19 cycles later, bin_out=17'd255, err=0, ovf=0.
REQ-032 Maximum operand: defaults, bcd_in=20'h99999 -> bin_out=17'd99999=17'h1869F, ovf=0.
REQ-033 Overflow case:
  - Setup: NDIG=5, BIN_W=16, bcd_in=20'h70000.
  - Required response: ovf=1 and bin_out=16'h1170 (70000 mod 65536=4464).
REQ-034 Invalid digit: bcd_in=20'h0A123 -> done 2 cycles after start, err=1, bin_out=0, busy never above 1 cycle.
REQ-035 Reset mid-operation: rst=0 at SHIFT step 5, then start=1 held 3 cycles during a conversion.
  - Required after the reset: all outputs 0, no done pulse.
  - Required for the conversion: exactly one conversion runs and one done pulse occurs.
REQ-036 Back-to-back runs: start=1 permanently with bcd_in=20'h00001 then 20'h65535 -> consecutive done pulses 20 cycles apart, bin_out=1 then 65535.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin_pkg
// Description : Shared definitions for the serial BCD-to-binary converter.
//               Holds the FSM state encoding and the helper that sizes the
//               shift-step counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The counter must be able to hold the value BIN_W itself.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_corr.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_corr
// Description : Combinational per-digit correction for reverse double-dabble.
//               A digit of 8 or more after a right shift gets 3 subtracted.
// Ports       : i_digit - 4-bit digit after the shift
//               o_digit - corrected 4-bit digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_corr (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8) begin
            o_digit = i_digit - 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd2bin_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin_serial
// Description : Serial BCD-to-binary converter using the reverse
//               double-dabble algorithm, one shift step per clock.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-low reset
//               start   - conversion request, honoured only in IDLE
//               bcd_in  - packed BCD operand, digit 0 in bits [3:0]
//               busy    - high in LOAD and SHIFT
//               done    - one-cycle result-valid pulse
//               bin_out - binary result, held until the next accepted start
//               err     - operand contained a digit above 9
//               ovf     - operand value does not fit in BIN_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin_serial
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = 5,
    parameter int BIN_W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err,
    output logic                ovf
);

    localparam int c_bcd_w  = 4 * NDIG;
    localparam int c_work_w = c_bcd_w + BIN_W;
    localparam int c_cnt_w  = cnt_width(BIN_W);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_work_w-1:0]   r_work;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [BIN_W-1:0]      r_bin_out;
    logic                  r_err;
    logic                  r_ovf;

    logic [c_work_w-1:0]   w_shift;
    logic [c_bcd_w-1:0]    w_corr;
    logic [c_work_w-1:0]   w_work_nxt;
    logic                  w_bad_digit;
    logic                  w_last_step;

    // ------------------------------------------------------------------
    // Shift-and-correct datapath
    // ------------------------------------------------------------------
    assign w_shift = r_work >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_corr
            bcd_digit_corr u_corr (
                .i_digit (w_shift[BIN_W + 4*gi +: 4]),
                .o_digit (w_corr[4*gi +: 4])
            );
        end
    endgenerate

    assign w_work_nxt  = {w_corr, w_shift[BIN_W-1:0]};
    assign w_last_step = (r_cnt == c_last_step);

    // The operand sits untouched in the BCD half of the work register
    // during LOAD, so digit validity is checked there.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_work[BIN_W + 4*i +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy        = 1'b1;
                w_state_nxt = w_bad_digit ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Work register, step counter and held results
    // ------------------------------------------------------------------
    // The operand is captured on the accepting edge, so bcd_in may change
    // freely once start has been taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work <= {bcd_in, {BIN_W{1'b0}}};
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_bad_digit) begin
                        r_err     <= 1'b1;
                        r_bin_out <= '0;
                        r_ovf     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= r_cnt + c_cnt_one;
                    // Any value left in the BCD half after the final shift
                    // is the part of the operand above 2^BIN_W.
                    if (w_last_step) begin
                        r_bin_out <= w_work_nxt[BIN_W-1:0];
                        r_ovf     <= |w_work_nxt[c_work_w-1:BIN_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin_out = r_bin_out;
    assign err     = r_err;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd2bin_serial
// Description : Self-checking bench for bcd2bin_serial. Instance A uses the
//               default parameters, instance B uses BIN_W=16 to reach the
//               overflow cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_serial;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [19:0] bcd_a, bcd_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        err_a, err_b, ovf_a, ovf_b;
    logic [16:0] bin_a;
    logic [15:0] bin_b;

    int n_cmp;
    int n_bad;

    bcd2bin_serial #(.NDIG(5), .BIN_W(17)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bcd_in(bcd_a),
        .busy(busy_a), .done(done_a), .bin_out(bin_a), .err(err_a), .ovf(ovf_a)
    );

    bcd2bin_serial #(.NDIG(5), .BIN_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
        .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [19:0] bcd;
        logic [16:0] exp_bin;
        logic        exp_err;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion: start for one cycle, scramble bcd_in after acceptance,
    // then measure latency (cycle with start high = cycle 0) and busy cycles.
    task automatic run_conv(input int sel, input logic [19:0] bcd,
                            output int lat, output int busy_cyc,
                            output logic [16:0] bin, output logic e,
                            output logic o, output logic dbl);
        lat = -1; busy_cyc = 0; bin = '0; e = 1'b0; o = 1'b0;
        if (sel == 0) begin start_a = 1'b1; bcd_a = bcd; end
        else          begin start_b = 1'b1; bcd_b = bcd; end
        tick();
        if (sel == 0) begin start_a = 1'b0; bcd_a = 20'h31415; end
        else          begin start_b = 1'b0; bcd_b = 20'h31415; end
        for (int n = 0; n < 60; n++) begin
            if (get_busy(sel)) busy_cyc++;
            if (get_done(sel)) begin
                lat = n + 1;
                bin = (sel == 0) ? bin_a : {1'b0, bin_b};
                e   = (sel == 0) ? err_a : err_b;
                o   = (sel == 0) ? ovf_a : ovf_b;
                break;
            end
            tick();
        end
        tick();
        dbl = get_done(sel);
    endtask

    vec_t vecs[11];

    initial begin
        int lat, bcyc, bw, t1, t2, pulses;
        logic [16:0] bin, b1, b2;
        logic e, o, dbl;

        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        bcd_a = '0; bcd_b = '0;

        vecs[0]  = '{0, 20'h00000, 17'd0,     1'b0, 1'b0};
        vecs[1]  = '{0, 20'h00255, 17'd255,   1'b0, 1'b0};
        vecs[2]  = '{0, 20'h99999, 17'h1869F, 1'b0, 1'b0};
        vecs[3]  = '{0, 20'h65535, 17'd65535, 1'b0, 1'b0};
        vecs[4]  = '{0, 20'h12345, 17'd12345, 1'b0, 1'b0};
        vecs[5]  = '{0, 20'h0A123, 17'd0,     1'b1, 1'b0};
        vecs[6]  = '{0, 20'h0000F, 17'd0,     1'b1, 1'b0};
        vecs[7]  = '{1, 20'h70000, 17'h01170, 1'b0, 1'b1};
        vecs[8]  = '{1, 20'h99999, 17'd34463, 1'b0, 1'b1};
        vecs[9]  = '{1, 20'h65535, 17'd65535, 1'b0, 1'b0};
        vecs[10] = '{1, 20'h65536, 17'd0,     1'b0, 1'b1};

        // Reset with start asserted: nothing may be accepted.
        start_a = 1'b1; bcd_a = 20'h00042;
        tick(); tick(); tick();
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_bin",  bin_a, 0);
        check("reset_err_ovf", {err_a, ovf_a}, 0);

        // First edge with rst=1 accepts the still-asserted start.
        rst = 1'b1;
        tick();
        check("first_edge_accept_busy", busy_a, 1);
        start_a = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            if (done_a) begin pulses++; check("first_edge_bin", bin_a, 42); end
            tick();
        end
        check("first_edge_pulses", pulses, 1);

        // Table-driven conversions.
        foreach (vecs[i]) begin
            bw = (vecs[i].sel == 0) ? 17 : 16;
            run_conv(vecs[i].sel, vecs[i].bcd, lat, bcyc, bin, e, o, dbl);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_err ? 2 : bw + 2);
            check($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].exp_err ? 1 : bw + 1);
            check($sformatf("v%0d_bin", i), bin, vecs[i].exp_bin);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("v%0d_ovf", i), o, vecs[i].exp_ovf);
            check($sformatf("v%0d_done_one_cycle", i), dbl, 0);
        end

        // Reset in the middle of a conversion (after shift step 5).
        start_a = 1'b1; bcd_a = 20'h12345;
        tick();                  // accepted -> LOAD
        start_a = 1'b0;
        tick();                  // -> SHIFT
        for (int n = 0; n < 5; n++) tick();
        check("mid_busy_before_reset", busy_a, 1);
        rst = 1'b0;
        tick();
        check("mid_reset_busy", busy_a, 0);
        check("mid_reset_done", done_a, 0);
        check("mid_reset_bin",  bin_a, 0);
        check("mid_reset_err_ovf", {err_a, ovf_a}, 0);
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            if (done_a) pulses++;
            tick();
        end
        check("mid_reset_no_done", pulses, 0);

        // start held 3 cycles: only one conversion may run.
        start_a = 1'b1; bcd_a = 20'h00777;
        tick(); tick(); tick();
        start_a = 1'b0;
        pulses = 0; bin = '0;
        for (int n = 0; n < 40; n++) begin
            if (done_a) begin pulses++; bin = bin_a; end
            tick();
        end
        check("held_start_pulses", pulses, 1);
        check("held_start_bin", bin, 777);

        // Back-to-back with start held high.
        start_a = 1'b1; bcd_a = 20'h00001;
        tick();
        bcd_a = 20'h65535;
        t1 = -1; t2 = -1; b1 = '0; b2 = '0;
        for (int n = 0; n < 60; n++) begin
            if (done_a) begin
                if (t1 < 0) begin t1 = n; b1 = bin_a; end
                else if (t2 < 0) begin t2 = n; b2 = bin_a; end
            end
            tick();
        end
        start_a = 1'b0;
        check("b2b_first_seen", (t1 >= 0), 1);
        check("b2b_spacing", t2 - t1, 20);
        check("b2b_bin1", b1, 1);
        check("b2b_bin2", b2, 65535);
        for (int n = 0; n < 25; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
